// File: rtl/shift_reg_ctrl_pkg.sv
// Shared types and helpers for the shift register controller.
//   state_e   : controller states (IDLE, SHIFT, PARITY, DONE)
//   STATE_W   : state encoding width
//   cnt_width : bit width of a counter that must hold values 0..n-1 (minimum 1)
package shift_reg_ctrl_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/shift_reg_core.sv
// Shift register datapath: parallel load (priority) or shift right with zero fill.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   load       : capture D this edge
//   shift      : shift right one bit this edge (ignored when load is high)
//   D          : parallel input word
//   Q          : register contents
module shift_reg_core #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] data_q;

    // Load wins over shift; zero enters at the MSB on shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= D;
        end else if (shift) begin
            data_q <= {1'b0, data_q[WIDTH-1:1]};
        end
    end

    assign Q = data_q;

endmodule

// File: rtl/shift_reg_ctrl.sv
// Parallel-in, serial-out transfer controller. Accepts a word via
// load_valid/load_ready, shifts it out LSB first at one bit per DIV enabled
// clocks, then pulses done for one cycle.
// Optional feature: define SHIFT_REG_CTRL_PARITY_EN to append an even-parity
// bit (one tick long) after the data bits.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   D           : parallel word, sampled only at the accept edge
//   load_valid  : producer has a word on D
//   load_ready  : controller is idle and can accept
//   shift_en    : global enable for divider, bit counter and register
//   Q           : shift register contents
//   sout        : serial data bit
//   sout_valid  : sout carries a data or parity bit
//   busy        : transfer in progress (SHIFT, PARITY or DONE)
//   done        : one-cycle end-of-transfer pulse
module shift_reg_ctrl
    import shift_reg_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DIV   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] D,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic [WIDTH-1:0] Q,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BIT_W = cnt_width(WIDTH);
    localparam int unsigned DIV_W = cnt_width(DIV);

    state_e             state_q, state_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               load_c;
    logic               shift_c;
    logic               div_end_c;
    logic               last_bit_c;

`ifdef SHIFT_REG_CTRL_PARITY_EN
    logic               parity_q;
`endif

    assign div_end_c  = (div_q == DIV_W'(DIV - 1));
    assign last_bit_c = (bit_q == BIT_W'(WIDTH - 1));

    shift_reg_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .load  (load_c),
        .shift (shift_c),
        .D     (D),
        .Q     (Q)
    );

    // State register plus bit and divider counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            bit_q   <= '0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
        end
    end

`ifdef SHIFT_REG_CTRL_PARITY_EN
    // Even parity of the word, captured together with the load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else if (load_c) begin
            parity_q <= ^D;
        end
    end
`endif

    // Next-state, counter update and datapath control.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        div_d   = div_q;
        load_c  = 1'b0;
        shift_c = 1'b0;
        case (state_q)
            IDLE: begin
                // Acceptance is independent of shift_en.
                if (load_valid) begin
                    load_c  = 1'b1;
                    bit_d   = '0;
                    div_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    if (div_end_c) begin
                        div_d   = '0;
                        shift_c = 1'b1;
                        if (last_bit_c) begin
                            bit_d = '0;
`ifdef SHIFT_REG_CTRL_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = DONE;
`endif
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
            end
`ifdef SHIFT_REG_CTRL_PARITY_EN
            PARITY: begin
                if (shift_en) begin
                    if (div_end_c) begin
                        div_d   = '0;
                        state_d = DONE;
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from state and registers only; ready is masked while reset is held.
    always_comb begin
        load_ready = 1'b0;
        sout       = 1'b0;
        sout_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                load_ready = ~reset;
            end
            SHIFT: begin
                sout       = Q[0];
                sout_valid = 1'b1;
                busy       = 1'b1;
            end
            PARITY: begin
`ifdef SHIFT_REG_CTRL_PARITY_EN
                sout       = parity_q;
`endif
                sout_valid = 1'b1;
                busy       = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                load_ready = 1'b0;
            end
        endcase
    end

endmodule
